instr_fetch_seq: RTL and testbench
==================================

# instr_fetch_seq

Parametrised instruction store and fetch sequencer for the MIPS_Processor datapath. A host loads a program word-by-word while the block is idle. On `start`, the block streams instructions in order to the datapath, one per cycle, with stall back-pressure. Streaming ends on a halt opcode, an external `finish`, or a hard stop. This generalises the fixed 16-bit/256-entry load path with run control, sequencing and status.

## Interface
- `INSTR_W`, 16: instruction width in bits.
- `ADDR_W`, 8: address width; depth is 2**ADDR_W words.
- `HALT_OP`, {INSTR_W{1'b1}}: opcode that terminates a run.
- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  asynchronous, active-low reset (assert at 0, release synchronous to `clk`).
- `we`  in  1  program-store write enable.
- `instruction`  in  INSTR_W  write data.
- `instruct_dir`  in  ADDR_W  write address.
- `start`  in  1  begin a run from address 0; level-sampled.
- `finish`  in  1  abort the current run.
- `stall`  in  1  datapath back-pressure; holds the fetch.
- `fetch_instr`  out  INSTR_W  fetched instruction (registered).
- `fetch_pc`  out  ADDR_W  address of `fetch_instr` (registered).
- `fetch_valid`  out  1  `fetch_instr`/`fetch_pc` are a new fetch.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `wrap`  out  1  sticky: PC wrapped past the last address this run.
- `write_err`  out  1  one-cycle pulse: write attempted during RUN.
- `fetch_count`  out  ADDR_W+1  fetched-instruction counter (see Configuration).

## Operation
- Storage: 2**ADDR_W × INSTR_W synchronous RAM. It is not reset. One write port and one read port.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE/DONE with `we`=1: `mem[instruct_dir] <= instruction`.
- IDLE/DONE with `start`=1 and `we`=0: enter RUN. Set `pc <= 0`. Clear `wrap`. Clear `fetch_count`.
- `start` and `we` in the same cycle: the write is performed and `start` is ignored. State does not change. No error is flagged.
- RUN with `we`=1: the write is dropped. `write_err` is high for the next cycle only.
- RUN, `finish`=0, `stall`=0: each edge registers the following.
  - `fetch_instr <= mem[pc]`.
  - `fetch_pc <= pc`.
  - `fetch_valid <= 1`.
  - `pc <= pc+1`, modulo 2**ADDR_W.
- RUN, `stall`=1: `pc`, `fetch_instr`, `fetch_pc` and `fetch_valid` hold their values.
- Halt: if `mem[pc]` equals `HALT_OP` on a non-stalled RUN edge, the halt word is presented with `fetch_valid`=1. State moves to DONE on the same edge.
- `finish`=1 in RUN takes priority over fetch and stall. On that edge: state goes to DONE, `fetch_valid <= 0`, and no fetch occurs.
- Wrap: fetching address 2**ADDR_W−1 with a non-halt word sets `wrap` on that edge. The run continues from 0.
- DONE: `fetch_valid` is 0 from the edge after entry. Outputs otherwise hold. `start` re-enters RUN.
- `finish` in IDLE or DONE has no effect.

## Timing
- Reset values: state IDLE, `pc`=0, `fetch_instr`=0, `fetch_pc`=0, `fetch_valid`=0, `busy`=0, `done`=0, `wrap`=0, `write_err`=0, `fetch_count`=0.
- `start` sampled at edge N: `busy`=1 after N. The first `fetch_valid`=1 (address 0) appears after N+1 if unstalled.
- Throughput: one instruction per unstalled cycle. `fetch_valid` stays high across consecutive unstalled fetches.
- A word written at edge N is readable by a fetch at edge N+1 or later.
- Halt word at edge M: `done`=1 and `busy`=0 after M. `fetch_valid`=0 after M+1.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronously). Memory contents are retained.

## Configuration
- `FETCH_COUNT_EN` defined: `fetch_count` increments on every edge that registers a fetch, including the halt word. It saturates at 2**(ADDR_W+1)−1. It clears on `start`.
- `FETCH_COUNT_EN` undefined: `fetch_count` is tied to 0. No counter logic is synthesised.

## Test plan
- Load 0x1111 at 0, 0x2222 at 1, 0xFFFF at 2, then pulse `start`. Required fetches in order: (0, 0x1111), (1, 0x2222), (2, 0xFFFF). After that `done`=1 and `fetch_valid`=0. With the macro defined, `fetch_count`=3.
- Same program with `stall`=1 for 3 cycles after the first fetch. `fetch_pc` holds at 0 for those cycles. The sequence is otherwise unchanged with no duplicate or skipped addresses.
- Program with no halt word, ADDR_W=2. `wrap` rises on the fetch of address 3. The next `fetch_pc` is 0.
- Assert `finish` in RUN. After the next edge: `done`=1 and `fetch_valid`=0. `pc` does not advance on that edge.
- Assert `we` during RUN. `write_err` pulses for exactly one cycle. The target address keeps its old contents when re-read in a later run.
- Assert `reset`=0 mid-run. All outputs return to their reset values. After release, `start` re-runs the program intact from address 0.

Source files
------------

// File: rtl/instr_fetch_seq_if.sv
// ============================================================================
//  instr_fetch_seq_if : host load / run-control / fetch bus for instr_fetch_seq
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_seq_if #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
);
    logic               we;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  instruct_dir;
    logic               start;
    logic               finish;
    logic               stall;

    logic [INSTR_W-1:0] fetch_instr;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               fetch_valid;
    logic               busy;
    logic               done;
    logic               wrap;
    logic               write_err;
    logic [ADDR_W:0]    fetch_count;

    modport master (
        output we, instruction, instruct_dir, start, finish, stall,
        input  fetch_instr, fetch_pc, fetch_valid, busy, done, wrap,
               write_err, fetch_count
    );

    modport slave (
        input  we, instruction, instruct_dir, start, finish, stall,
        output fetch_instr, fetch_pc, fetch_valid, busy, done, wrap,
               write_err, fetch_count
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_seq.sv
// ============================================================================
//  instr_fetch_seq : program store plus in-order fetch sequencer with run control.
//  Optional fetch counter enabled by defining FETCH_COUNT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_seq #(
    parameter int                 INSTR_W = 16,
    parameter int                 ADDR_W  = 8,
    parameter logic [INSTR_W-1:0] HALT_OP = {INSTR_W{1'b1}}
) (
    input wire                clk,
    input wire                reset,
    instr_fetch_seq_if.slave  bus
);

    localparam int                c_depth    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_pc  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_pc_one   = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [INSTR_W-1:0] r_mem [c_depth];
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_fetch_instr;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_fetch_valid;
    logic               r_wrap;
    logic               r_write_err;

    logic [INSTR_W-1:0] w_rd_data;
    logic               w_wr_en;
    logic               w_start;
    logic               w_fetch;
    logic               w_halt;

    assign w_rd_data = r_mem[r_pc];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A write in IDLE/DONE wins over start; finish in RUN wins over stall and fetch.
    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_start      = 1'b0;
        w_fetch      = 1'b0;
        w_halt       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.we) begin
                    w_wr_en = 1'b1;
                end else if (bus.start) begin
                    w_start      = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.finish) begin
                    w_state_next = S_DONE;
                end else if (!bus.stall) begin
                    w_fetch = 1'b1;
                    if (w_rd_data == HALT_OP) begin
                        w_halt       = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Program store is deliberately left out of reset so a reset keeps the program.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[bus.instruct_dir] <= bus.instruction;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= '0;
            r_fetch_instr <= '0;
            r_fetch_pc    <= '0;
            r_fetch_valid <= 1'b0;
            r_wrap        <= 1'b0;
            r_write_err   <= 1'b0;
        end else begin
            r_write_err <= (r_state == S_RUN) && bus.we;

            if (w_start) begin
                r_pc   <= '0;
                r_wrap <= 1'b0;
            end

            if (w_fetch) begin
                r_fetch_instr <= w_rd_data;
                r_fetch_pc    <= r_pc;
                r_pc          <= r_pc + c_pc_one;
                if (!w_halt && (r_pc == c_last_pc)) begin
                    r_wrap <= 1'b1;
                end
            end

            // Stalled RUN keeps fetch_valid; anything else that is not a fetch drops it.
            if (w_fetch) begin
                r_fetch_valid <= 1'b1;
            end else if ((r_state != S_RUN) || bus.finish) begin
                r_fetch_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_COUNT_EN
    localparam logic [ADDR_W:0] c_count_max = {(ADDR_W+1){1'b1}};
    localparam logic [ADDR_W:0] c_count_one = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] r_fetch_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_count <= '0;
        end else if (w_start) begin
            r_fetch_count <= '0;
        end else if (w_fetch && (r_fetch_count != c_count_max)) begin
            r_fetch_count <= r_fetch_count + c_count_one;
        end
    end

    assign bus.fetch_count = r_fetch_count;
`else
    assign bus.fetch_count = '0;
`endif

    assign bus.fetch_instr = r_fetch_instr;
    assign bus.fetch_pc    = r_fetch_pc;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.wrap        = r_wrap;
    assign bus.write_err   = r_write_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
// ============================================================================
//  tb_instr_fetch_seq : scoreboard bench for instr_fetch_seq (4-word store).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_seq;

    localparam int          INSTR_W = 16;
    localparam int          ADDR_W  = 2;
    localparam int          DEPTH   = 4;
    localparam logic [15:0] HALT    = 16'hFFFF;
`ifdef FETCH_COUNT_EN
    localparam bit          COUNT_EN = 1'b1;
`else
    localparam bit          COUNT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_seq_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

    instr_fetch_seq #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W),
        .HALT_OP (HALT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_t;

    fetch_t      sb_q[$];
    logic [15:0] model_mem [DEPTH];
    bit          m_run, m_done, m_wrap, m_valid, m_werr;
    int          m_pc, m_count;
    logic [1:0]  m_last_pc;
    logic [15:0] m_last_instr;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_wrap = 0; m_valid = 0; m_werr = 0;
        m_pc = 0; m_count = 0; m_last_pc = '0; m_last_instr = '0;
        sb_q.delete();
    endtask

    task automatic check_status(input string tag, input bit with_pc);
        check({tag, ".busy"},        bus.busy,        m_run);
        check({tag, ".done"},        bus.done,        m_done);
        check({tag, ".wrap"},        bus.wrap,        m_wrap);
        check({tag, ".write_err"},   bus.write_err,   m_werr);
        check({tag, ".fetch_valid"}, bus.fetch_valid, m_valid);
        check({tag, ".fetch_count"}, bus.fetch_count, COUNT_EN ? m_count : 0);
        if (with_pc) begin
            check({tag, ".hold_pc"},    bus.fetch_pc,    m_last_pc);
            check({tag, ".hold_instr"}, bus.fetch_instr, m_last_instr);
        end
    endtask

    // Advance the model by one edge from the currently driven inputs, then compare.
    task automatic tick();
        fetch_t e;
        bit     fetched;
        fetched = 0;
        m_werr  = m_run && bus.we;
        if (!m_run) begin
            m_valid = 0;
            if (bus.we) begin
                model_mem[bus.instruct_dir] = bus.instruction;
            end else if (bus.start) begin
                m_run = 1; m_done = 0; m_pc = 0; m_wrap = 0; m_count = 0;
            end
        end else if (bus.finish) begin
            m_run = 0; m_done = 1; m_valid = 0;
        end else if (!bus.stall) begin
            e.pc    = m_pc[1:0];
            e.instr = model_mem[m_pc];
            sb_q.push_back(e);
            fetched = 1;
            m_valid = 1;
            if (e.instr == HALT) begin
                m_run = 0; m_done = 1;
            end else if (m_pc == DEPTH - 1) begin
                m_wrap = 1;
            end
            m_pc = (m_pc + 1) % DEPTH;
            if (m_count < 2 * DEPTH - 1) m_count++;
        end
        @(posedge clk);
        #1;
        if (fetched) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("fetch_pc",    bus.fetch_pc,    e.pc);
                check("fetch_instr", bus.fetch_instr, e.instr);
                m_last_pc    = e.pc;
                m_last_instr = e.instr;
            end
        end
        check_status("tick", !fetched);
    endtask

    task automatic write_word(input logic [1:0] addr, input logic [15:0] data);
        bus.we           = 1'b1;
        bus.instruct_dir = addr;
        bus.instruction  = data;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (m_run && n < budget) begin
            tick();
            n++;
        end
        check("run_timeout", {31'd0, m_run}, 32'd0);
    endtask

    initial begin
        bus.we = 1'b0; bus.instruction = '0; bus.instruct_dir = '0;
        bus.start = 1'b0; bus.finish = 1'b0; bus.stall = 1'b0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        #2 reset = 1'b0;
        #2 check_status("reset", 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;

        // Basic program ending in a halt word.
        write_word(2'd0, 16'h1111);
        write_word(2'd1, 16'h2222);
        write_word(2'd2, HALT);
        write_word(2'd3, 16'h3333);
        start_run();
        run_to_done(20);
        tick();
        tick();
        check("sb_empty_basic", sb_q.size(), 0);

        // Three stall cycles after the first fetch.
        start_run();
        tick();
        bus.stall = 1'b1;
        repeat (3) tick();
        bus.stall = 1'b0;
        run_to_done(20);
        tick();

        // No halt word: wrap past address 3, counter saturation, then finish.
        write_word(2'd2, 16'h4444);
        start_run();
        repeat (10) tick();
        bus.stall = 1'b1;
        bus.finish = 1'b1;
        tick();
        bus.stall = 1'b0;
        bus.finish = 1'b0;
        tick();

        // Write during RUN is dropped and flagged; old word survives into the next run.
        write_word(2'd2, HALT);
        start_run();
        tick();
        bus.we = 1'b1; bus.instruct_dir = 2'd1; bus.instruction = 16'hDEAD;
        tick();
        bus.we = 1'b0;
        tick();
        run_to_done(20);
        start_run();
        run_to_done(20);

        // start together with we: write happens, start ignored.
        bus.start = 1'b1; bus.we = 1'b1; bus.instruct_dir = 2'd3; bus.instruction = 16'h5555;
        tick();
        bus.start = 1'b0; bus.we = 1'b0;
        tick();

        // finish while DONE has no effect.
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;

        // Asynchronous reset mid-run, then re-run the retained program.
        start_run();
        tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_status("midrun_reset", 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        start_run();
        run_to_done(20);
        tick();
        check("sb_empty_final", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
